// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and defaults for the register-fetch hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam int scoreboard_depth_gp = 4;
  localparam int reg_addr_width_gp   = 5;

  typedef logic [reg_addr_width_gp-1:0] rvga_reg;

  typedef struct packed {
    logic    valid;
    rvga_reg rd;
  } rvga_sb_entry;

endpackage

// File: rtl/hazard_scoreboard_sb_fifo.sv
// In-order tracker of in-flight destination registers: circular buffer with
// push at tail, pop at head, and flush-N that rewinds the tail. Exposes every
// slot's valid bit and rd index so the caller can compare all entries in parallel.
module hazard_scoreboard_sb_fifo #(
  parameter int depth_p = 4,
  parameter int width_p = 5
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  push_i,
  input  logic [width_p-1:0]                    push_data_i,
  input  logic                                  pop_i,
  input  logic                                  flush_i,
  input  logic [$clog2(depth_p):0]              flush_cnt_i,
  input  logic                                  mask_head_i,
  output logic [depth_p-1:0]                    match_valid_o,
  output logic [depth_p-1:0][width_p-1:0]       data_o,
  output logic [$clog2(depth_p):0]              count_o
);

  localparam int PW = $clog2(depth_p);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [depth_p-1:0]              valid_q, valid_d;
  logic [depth_p-1:0][width_p-1:0] data_q, data_d;
  logic [PW-1:0]                   head_q, head_d;
  logic [PW-1:0]                   tail_q, tail_d;
  logic [CW-1:0]                   count_q, count_d;
  logic [CW-1:0]                   squash;
  logic                            pop_en;
  logic                            push_en;

  assign pop_en  = pop_i & (count_q != '0);
  assign push_en = push_i & ~flush_i;

  // Next state: pop oldest first, then either push or squash youngest.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    squash  = '0;
    if (pop_en) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_ONE;
      count_d         = count_q - CNT_ONE;
    end
    if (push_en) begin
      valid_d[tail_q] = 1'b1;
      data_d[tail_q]  = push_data_i;
      tail_d          = tail_q + PTR_ONE;
      count_d         = count_d + CNT_ONE;
    end
    if (flush_i) begin
      squash = (flush_cnt_i < count_d) ? flush_cnt_i : count_d;
      for (int i = 0; i < depth_p; i++) begin
        if (CW'(i) < squash) begin
          valid_d[tail_q - PW'(i) - PTR_ONE] = 1'b0;
        end
      end
      tail_d  = tail_q - PW'(squash);
      count_d = count_d - squash;
    end
  end

  // Compare view: head slot hidden while it is retiring, when the caller asks.
  always_comb begin
    match_valid_o = valid_q;
    if (mask_head_i) begin
      match_valid_o[head_q] = 1'b0;
    end
  end

  // State registers, synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      data_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign data_o  = data_q;
  assign count_o = count_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue controller at the decode/rfetch boundary. Stalls on read-after-write
// hazards against in-flight writes, on a full tracker, or on external request.
// Optional macro HAZARD_WB_BYPASS_EN: the retiring head entry stops matching in
// its writeback cycle (write-first regfile), so dependents issue a cycle earlier.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int depth_p          = scoreboard_depth_gp,
  parameter int reg_addr_width_p = reg_addr_width_gp
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          dec_v_i,
  input  logic [reg_addr_width_p-1:0]   dec_rs1_i,
  input  logic                          dec_rs1_v_i,
  input  logic [reg_addr_width_p-1:0]   dec_rs2_i,
  input  logic                          dec_rs2_v_i,
  input  logic [reg_addr_width_p-1:0]   dec_rd_i,
  input  logic                          dec_rd_w_v_i,
  input  logic                          ext_stall_i,
  input  logic                          wb_v_i,
  input  logic                          flush_v_i,
  input  logic [$clog2(depth_p):0]      flush_cnt_i,
  output logic                          stall_v_o,
  output logic                          issue_o,
  output logic [$clog2(depth_p):0]      inflight_cnt_o
);

  localparam int CW = $clog2(depth_p) + 1;

  logic [depth_p-1:0]                       match_valid;
  logic [depth_p-1:0][reg_addr_width_p-1:0] entry_rd;
  logic [CW-1:0]                            count;
  logic                                     mask_head;
  logic                                     rs1_hit, rs2_hit;
  logic                                     haz, full, push;

`ifdef HAZARD_WB_BYPASS_EN
  assign mask_head = wb_v_i;
`else
  assign mask_head = 1'b0;
`endif

  hazard_scoreboard_sb_fifo #(
    .depth_p (depth_p),
    .width_p (reg_addr_width_p)
  ) u_fifo (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .push_i        (push),
    .push_data_i   (dec_rd_i),
    .pop_i         (wb_v_i),
    .flush_i       (flush_v_i),
    .flush_cnt_i   (flush_cnt_i),
    .mask_head_i   (mask_head),
    .match_valid_o (match_valid),
    .data_o        (entry_rd),
    .count_o       (count)
  );

  // Parallel compare of both sources against every live tracked rd.
  always_comb begin
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    for (int i = 0; i < depth_p; i++) begin
      if (match_valid[i] && (entry_rd[i] == dec_rs1_i)) rs1_hit = 1'b1;
      if (match_valid[i] && (entry_rd[i] == dec_rs2_i)) rs2_hit = 1'b1;
    end
  end

  assign haz = dec_v_i &
               ((dec_rs1_v_i & (dec_rs1_i != '0) & rs1_hit) |
                (dec_rs2_v_i & (dec_rs2_i != '0) & rs2_hit));

  // Full uses the registered count; a same-cycle pop does not make room.
  assign full      = (count == CW'(depth_p));
  assign stall_v_o = ext_stall_i | haz | (dec_v_i & dec_rd_w_v_i & full);
  assign issue_o   = dec_v_i & ~stall_v_o & ~flush_v_i & ~rst_i;
  assign push      = issue_o & dec_rd_w_v_i & (dec_rd_i != '0);

  assign inflight_cnt_o = count;

`ifndef SYNTHESIS
  // Writeback retiring from an empty tracker means upstream bookkeeping broke.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wb_v_i) begin
      assert (count != '0) else $error("hazard_scoreboard: writeback with no tracked entry");
    end
  end
`endif

endmodule
